ibex_cx_issue: RTL and testbench

- Custom-extension (CX) issue/response unit between the ID stage and the eFPGA fabric.
- Directly feeds the execute block's eFPGA result and response-valid inputs.
- Takes an eFPGA instruction (optype, two operands), issues it to the fabric with a valid/ready request, then tracks the outstanding request by tag.
- Returns the result as a single-cycle response pulse, covering fixed-latency mode, timeout and flush.

---
 rtl/ibex_cx_issue_pkg.sv | 32 +++
 rtl/ibex_cx_issue_if.sv | 32 +++
 rtl/ibex_cx_issue_timer.sv | 46 ++++
 rtl/ibex_cx_issue.sv | 156 +++++++++++++++
 tb/tb_ibex_cx_issue.sv | 393 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ibex_cx_issue_pkg.sv
`default_nettype none
// ============================================================================
// ibex_cx_issue_pkg : shared types and constants for the CX issue unit
// Revision 1.0
// ============================================================================
package ibex_cx_issue_pkg;

    localparam int CX_TAG_W   = 3;
    localparam int CX_TIMEOUT = 64;
    localparam int CX_DELAY_W = 4;

    typedef enum logic [1:0] {
        CX_IDLE = 2'd0,
        CX_REQ  = 2'd1,
        CX_WAIT = 2'd2,
        CX_RESP = 2'd3
    } cx_state_e;

    typedef enum logic [1:0] {
        CX_OP_0 = 2'd0,
        CX_OP_1 = 2'd1,
        CX_OP_2 = 2'd2,
        CX_OP_3 = 2'd3
    } cx_optype_e;

    // A non-zero delay selects fixed-latency completion instead of a handshake.
    function automatic logic cx_is_fixed(input logic [CX_DELAY_W-1:0] delay);
        return delay != '0;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ibex_cx_issue_if.sv
`default_nettype none
// ============================================================================
// ibex_cx_issue_if : request/response bus between the CX unit and the fabric
// Revision 1.0
// ============================================================================
interface ibex_cx_issue_if #(
    parameter int TAG_W = 3
);
    logic             cx_req_valid_o;
    logic             cx_req_ready_i;
    logic [1:0]       cx_req_optype_o;
    logic [31:0]      cx_req_op_a_o;
    logic [31:0]      cx_req_op_b_o;
    logic [TAG_W-1:0] cx_req_tag_o;
    logic             cx_resp_valid_i;
    logic [TAG_W-1:0] cx_resp_tag_i;
    logic [31:0]      cx_resp_data_i;
    logic             cx_resp_ready_o;

    modport master (
        output cx_req_valid_o, cx_req_optype_o, cx_req_op_a_o, cx_req_op_b_o,
               cx_req_tag_o, cx_resp_ready_o,
        input  cx_req_ready_i, cx_resp_valid_i, cx_resp_tag_i, cx_resp_data_i
    );

    modport slave (
        input  cx_req_valid_o, cx_req_optype_o, cx_req_op_a_o, cx_req_op_b_o,
               cx_req_tag_o, cx_resp_ready_o,
        output cx_req_ready_i, cx_resp_valid_i, cx_resp_tag_i, cx_resp_data_i
    );
endinterface
`default_nettype wire

// File: rtl/ibex_cx_issue_timer.sv
`default_nettype none
// ============================================================================
// ibex_cx_issue_timer : saturating WAIT-cycle counter with latency/timeout taps
// Revision 1.0
// ============================================================================
module ibex_cx_issue_timer
    import ibex_cx_issue_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = CX_TIMEOUT
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  clr_i,
    input  wire logic                  en_i,
    input  wire logic [CX_DELAY_W-1:0] delay_i,
    output logic                       match_o,
    output logic                       timeout_o
);

    localparam int                CNT_W   = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign match_o   = (delay_i != '0) && ((32'(delay_i) - 32'd1) == 32'(cnt_q));
    assign timeout_o = (cnt_q == CNT_MAX);

endmodule
`default_nettype wire

// File: rtl/ibex_cx_issue.sv
`default_nettype none
// ============================================================================
// ibex_cx_issue : issues eFPGA custom instructions and returns one-cycle results
// Revision 1.0
// ============================================================================
module ibex_cx_issue
    import ibex_cx_issue_pkg::*;
#(
    parameter int TAG_W          = CX_TAG_W,
    parameter int TIMEOUT_CYCLES = CX_TIMEOUT
) (
    input  wire logic                  clk,
    input  wire logic                  rst,
    input  wire logic                  en_i,
    input  wire logic                  flush_i,
    input  wire logic [1:0]            optype_i,
    input  wire logic [31:0]           operand_a_i,
    input  wire logic [31:0]           operand_b_i,
    input  wire logic [CX_DELAY_W-1:0] delay_i,
    ibex_cx_issue_if.master            cx,
    output logic                       resp_valid_o,
    output logic [31:0]                result_o,
    output logic                       err_o,
    output logic                       busy_o
);

    cx_state_e               state_q, state_d;
    cx_optype_e              optype_q, optype_d;
    logic [31:0]             op_a_q, op_a_d;
    logic [31:0]             op_b_q, op_b_d;
    logic [CX_DELAY_W-1:0]   delay_q, delay_d;
    logic [TAG_W-1:0]        tag_q, tag_d;
    logic [TAG_W-1:0]        issued_tag_q, issued_tag_d;
    logic [31:0]             result_q, result_d;
    logic                    err_q, err_d;

    logic fixed_mode;
    logic req_hs;
    logic resp_hit;
    logic timer_match;
    logic timer_timeout;

    assign fixed_mode = cx_is_fixed(delay_q);
    assign req_hs     = (state_q == CX_REQ) && cx.cx_req_ready_i;
    assign resp_hit   = !fixed_mode && cx.cx_resp_valid_i && (cx.cx_resp_tag_i == issued_tag_q);

    // Counter sits at zero outside WAIT, so it restarts on every handshake.
    ibex_cx_issue_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timer (
        .clk       (clk),
        .rst       (rst),
        .clr_i     (state_q != CX_WAIT),
        .en_i      (state_q == CX_WAIT),
        .delay_i   (delay_q),
        .match_o   (timer_match),
        .timeout_o (timer_timeout)
    );

    always_comb begin
        state_d      = state_q;
        optype_d     = optype_q;
        op_a_d       = op_a_q;
        op_b_d       = op_b_q;
        delay_d      = delay_q;
        tag_d        = tag_q;
        issued_tag_d = issued_tag_q;
        result_d     = result_q;
        err_d        = err_q;

        case (state_q)
            CX_IDLE: begin
                if (en_i && !flush_i) begin
                    optype_d = cx_optype_e'(optype_i);
                    op_a_d   = operand_a_i;
                    op_b_d   = operand_b_i;
                    delay_d  = delay_i;
                    state_d  = CX_REQ;
                end
            end
            CX_REQ: begin
                // The fabric has seen the handshake even if a flush lands now.
                if (req_hs) begin
                    issued_tag_d = tag_q;
                    tag_d        = tag_q + 1'b1;
                    state_d      = CX_WAIT;
                end
            end
            CX_WAIT: begin
                if (resp_hit) begin
                    result_d = cx.cx_resp_data_i;
                    err_d    = 1'b0;
                    state_d  = CX_RESP;
                end else if (fixed_mode && timer_match) begin
                    result_d = cx.cx_resp_data_i;
                    err_d    = 1'b0;
                    state_d  = CX_RESP;
                end else if (timer_timeout) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    state_d  = CX_RESP;
                end
            end
            CX_RESP: begin
                state_d = CX_IDLE;
            end
            default: begin
                state_d = CX_IDLE;
            end
        endcase

        if (flush_i) begin
            state_d  = CX_IDLE;
            result_d = result_q;
            err_d    = err_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= CX_IDLE;
            optype_q     <= CX_OP_0;
            op_a_q       <= '0;
            op_b_q       <= '0;
            delay_q      <= '0;
            tag_q        <= '0;
            issued_tag_q <= '0;
            result_q     <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            optype_q     <= optype_d;
            op_a_q       <= op_a_d;
            op_b_q       <= op_b_d;
            delay_q      <= delay_d;
            tag_q        <= tag_d;
            issued_tag_q <= issued_tag_d;
            result_q     <= result_d;
            err_q        <= err_d;
        end
    end

    assign cx.cx_req_valid_o  = (state_q == CX_REQ);
    assign cx.cx_req_optype_o = optype_q;
    assign cx.cx_req_op_a_o   = op_a_q;
    assign cx.cx_req_op_b_o   = op_b_q;
    assign cx.cx_req_tag_o    = tag_q;
    assign cx.cx_resp_ready_o = (state_q == CX_WAIT) && !fixed_mode;

    assign resp_valid_o = (state_q == CX_RESP) && !flush_i;
    assign err_o        = resp_valid_o && err_q;
    assign result_o     = result_q;
    assign busy_o       = (state_q != CX_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ibex_cx_issue.sv
`default_nettype none
// ============================================================================
// tb_ibex_cx_issue : scenario bench with a result scoreboard for ibex_cx_issue
// Revision 1.0
// ============================================================================
module tb_ibex_cx_issue;

    localparam int TAG_W = 3;
    localparam int TMO   = 8;

    typedef struct packed {
        logic [31:0] res;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        en_i;
    logic        flush_i;
    logic [1:0]  optype_i;
    logic [31:0] operand_a_i;
    logic [31:0] operand_b_i;
    logic [3:0]  delay_i;
    logic        resp_valid_o;
    logic [31:0] result_o;
    logic        err_o;
    logic        busy_o;

    int   total  = 0;
    int   bad    = 0;
    int   pulses = 0;
    int   pushed = 0;
    exp_t exp_q[$];

    ibex_cx_issue_if #(.TAG_W(TAG_W)) cx_if ();

    ibex_cx_issue #(
        .TAG_W          (TAG_W),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en_i         (en_i),
        .flush_i      (flush_i),
        .optype_i     (optype_i),
        .operand_a_i  (operand_a_i),
        .operand_b_i  (operand_b_i),
        .delay_i      (delay_i),
        .cx           (cx_if),
        .resp_valid_o (resp_valid_o),
        .result_o     (result_o),
        .err_o        (err_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    // Scoreboard: every response pulse must match the oldest expected result.
    always @(negedge clk) begin
        if (!rst && resp_valid_o) begin
            exp_t e;
            pulses++;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_pulse got result=%h err=%b, wanted no pulse", result_o, err_o);
            end else begin
                e = exp_q.pop_front();
                if (result_o !== e.res || err_o !== e.err) begin
                    bad++;
                    $display("FAIL resp_scoreboard got result=%h err=%b, wanted result=%h err=%b",
                             result_o, err_o, e.res, e.err);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_resp(input logic [31:0] res, input logic err);
        exp_t e;
        e.res = res;
        e.err = err;
        exp_q.push_back(e);
        pushed++;
    endtask

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] d, input logic rdy);
        en_i                 = 1'b1;
        optype_i             = op;
        operand_a_i          = a;
        operand_b_i          = b;
        delay_i              = d;
        cx_if.cx_req_ready_i = rdy;
        tick();
        en_i = 1'b0;
    endtask

    task automatic test_reset();
        rst                   = 1'b1;
        en_i                  = 1'b0;
        flush_i               = 1'b0;
        optype_i              = '0;
        operand_a_i           = '0;
        operand_b_i           = '0;
        delay_i               = '0;
        cx_if.cx_req_ready_i  = 1'b0;
        cx_if.cx_resp_valid_i = 1'b0;
        cx_if.cx_resp_tag_i   = '0;
        cx_if.cx_resp_data_i  = '0;
        tick();
        tick();
        total++;
        if ({cx_if.cx_req_valid_o, cx_if.cx_resp_ready_o, resp_valid_o, err_o, busy_o} !== 5'b0) begin
            bad++;
            $display("FAIL reset_flags got %b, wanted 00000",
                     {cx_if.cx_req_valid_o, cx_if.cx_resp_ready_o, resp_valid_o, err_o, busy_o});
        end
        total++;
        if (cx_if.cx_req_tag_o !== 3'd0 || result_o !== 32'd0) begin
            bad++;
            $display("FAIL reset_tag_result got tag=%0d result=%h, wanted 0 and 0",
                     cx_if.cx_req_tag_o, result_o);
        end
        total++;
        if ({cx_if.cx_req_optype_o, cx_if.cx_req_op_a_o, cx_if.cx_req_op_b_o} !== 66'd0) begin
            bad++;
            $display("FAIL reset_payload got op=%0d a=%h b=%h, wanted zeros",
                     cx_if.cx_req_optype_o, cx_if.cx_req_op_a_o, cx_if.cx_req_op_b_o);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_handshake();
        issue(2'd2, 32'h10, 32'h20, 4'd0, 1'b1);
        total++;
        if (cx_if.cx_req_valid_o !== 1'b1 || cx_if.cx_req_tag_o !== 3'd0 || cx_if.cx_req_optype_o !== 2'd2 ||
            cx_if.cx_req_op_a_o !== 32'h10 || cx_if.cx_req_op_b_o !== 32'h20) begin
            bad++;
            $display("FAIL hs_request got v=%b tag=%0d op=%0d a=%h b=%h, wanted 1 0 2 10 20",
                     cx_if.cx_req_valid_o, cx_if.cx_req_tag_o, cx_if.cx_req_optype_o,
                     cx_if.cx_req_op_a_o, cx_if.cx_req_op_b_o);
        end
        tick();
        cx_if.cx_req_ready_i = 1'b0;
        total++;
        if (cx_if.cx_req_tag_o !== 3'd1 || cx_if.cx_req_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL hs_tag_advance got tag=%0d v=%b, wanted 1 0", cx_if.cx_req_tag_o, cx_if.cx_req_valid_o);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (cx_if.cx_resp_ready_o !== 1'b1 || resp_valid_o !== 1'b0) begin
                bad++;
                $display("FAIL hs_wait_%0d got ready=%b pulse=%b, wanted 1 0", i, cx_if.cx_resp_ready_o, resp_valid_o);
            end
            // One wrong-tag response that must be swallowed silently.
            cx_if.cx_resp_valid_i = (i == 1);
            cx_if.cx_resp_tag_i   = 3'd5;
            cx_if.cx_resp_data_i  = 32'hDEAD;
            tick();
        end
        cx_if.cx_resp_valid_i = 1'b1;
        cx_if.cx_resp_tag_i   = 3'd0;
        cx_if.cx_resp_data_i  = 32'hCAFE;
        expect_resp(32'hCAFE, 1'b0);
        tick();
        cx_if.cx_resp_valid_i = 1'b0;
        total++;
        if (resp_valid_o !== 1'b1) begin
            bad++;
            $display("FAIL hs_pulse got %b, wanted 1", resp_valid_o);
        end
        tick();
        total++;
        if (resp_valid_o !== 1'b0 || busy_o !== 1'b0 || result_o !== 32'hCAFE) begin
            bad++;
            $display("FAIL hs_after got pulse=%b busy=%b result=%h, wanted 0 0 cafe", resp_valid_o, busy_o, result_o);
        end
    endtask

    task automatic test_fixed();
        issue(2'd1, 32'h11, 32'h22, 4'd5, 1'b1);
        total++;
        if (cx_if.cx_req_tag_o !== 3'd1) begin
            bad++;
            $display("FAIL fix_tag got %0d, wanted 1", cx_if.cx_req_tag_o);
        end
        tick();
        cx_if.cx_req_ready_i = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            total++;
            if (cx_if.cx_resp_ready_o !== 1'b0 || resp_valid_o !== 1'b0) begin
                bad++;
                $display("FAIL fix_wait_%0d got ready=%b pulse=%b, wanted 0 0", k, cx_if.cx_resp_ready_o, resp_valid_o);
            end
            cx_if.cx_resp_data_i = (k == 5) ? 32'h1234 : (32'hDEAD0000 | 32'(k));
            if (k == 5) expect_resp(32'h1234, 1'b0);
            tick();
        end
        total++;
        if (resp_valid_o !== 1'b1 || cx_if.cx_resp_ready_o !== 1'b0) begin
            bad++;
            $display("FAIL fix_pulse got pulse=%b ready=%b, wanted 1 0", resp_valid_o, cx_if.cx_resp_ready_o);
        end
        tick();
    endtask

    task automatic test_backpressure();
        issue(2'd0, 32'hA0, 32'hB0, 4'd1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            total++;
            if (cx_if.cx_req_valid_o !== 1'b1 || cx_if.cx_req_op_a_o !== 32'hA0 || cx_if.cx_req_tag_o !== 3'd2) begin
                bad++;
                $display("FAIL bp_stable_%0d got v=%b a=%h tag=%0d, wanted 1 a0 2",
                         i, cx_if.cx_req_valid_o, cx_if.cx_req_op_a_o, cx_if.cx_req_tag_o);
            end
            operand_a_i = $urandom;
            tick();
        end
        cx_if.cx_req_ready_i = 1'b1;
        tick();
        cx_if.cx_req_ready_i = 1'b0;
        total++;
        if (cx_if.cx_req_tag_o !== 3'd3 || cx_if.cx_req_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL bp_handshake got tag=%0d v=%b, wanted 3 0", cx_if.cx_req_tag_o, cx_if.cx_req_valid_o);
        end
        cx_if.cx_resp_data_i = 32'h5A5A;
        expect_resp(32'h5A5A, 1'b0);
        tick();
        tick();
        total++;
        if (cx_if.cx_req_tag_o !== 3'd3) begin
            bad++;
            $display("FAIL bp_single_inc got tag=%0d, wanted 3", cx_if.cx_req_tag_o);
        end
    endtask

    task automatic test_flush_wait();
        issue(2'd3, 32'h1, 32'h2, 4'd0, 1'b1);
        total++;
        if (cx_if.cx_req_tag_o !== 3'd3) begin
            bad++;
            $display("FAIL fl_tag3 got %0d, wanted 3", cx_if.cx_req_tag_o);
        end
        tick();
        cx_if.cx_req_ready_i = 1'b0;
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        total++;
        if (busy_o !== 1'b0 || resp_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL fl_idle got busy=%b pulse=%b, wanted 0 0", busy_o, resp_valid_o);
        end
        cx_if.cx_resp_valid_i = 1'b1;
        cx_if.cx_resp_tag_i   = 3'd3;
        cx_if.cx_resp_data_i  = 32'h0057A1E0;
        issue(2'd2, 32'h3, 32'h4, 4'd0, 1'b1);
        total++;
        if (cx_if.cx_req_tag_o !== 3'd4) begin
            bad++;
            $display("FAIL fl_tag4 got %0d, wanted 4", cx_if.cx_req_tag_o);
        end
        tick();
        cx_if.cx_req_ready_i = 1'b0;
        tick();
        total++;
        if (busy_o !== 1'b1 || resp_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL fl_stale_drop got busy=%b pulse=%b, wanted 1 0", busy_o, resp_valid_o);
        end
        cx_if.cx_resp_tag_i  = 3'd4;
        cx_if.cx_resp_data_i = 32'hBEEF;
        expect_resp(32'hBEEF, 1'b0);
        tick();
        cx_if.cx_resp_valid_i = 1'b0;
        tick();
        total++;
        if (result_o !== 32'hBEEF) begin
            bad++;
            $display("FAIL fl_result got %h, wanted beef", result_o);
        end
    endtask

    task automatic test_timeout();
        issue(2'd0, 32'h7, 32'h8, 4'd0, 1'b1);
        tick();
        cx_if.cx_req_ready_i = 1'b0;
        for (int k = 1; k <= TMO; k++) begin
            total++;
            if (resp_valid_o !== 1'b0) begin
                bad++;
                $display("FAIL to_early_%0d got pulse=%b, wanted 0", k, resp_valid_o);
            end
            if (k == TMO) expect_resp(32'h0, 1'b1);
            tick();
        end
        total++;
        if (resp_valid_o !== 1'b1 || err_o !== 1'b1) begin
            bad++;
            $display("FAIL to_pulse got pulse=%b err=%b, wanted 1 1", resp_valid_o, err_o);
        end
        tick();
        // Flush in the very cycle the timeout fires must kill the response.
        issue(2'd0, 32'h9, 32'hA, 4'd0, 1'b1);
        tick();
        cx_if.cx_req_ready_i = 1'b0;
        for (int k = 1; k < TMO; k++) tick();
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        total++;
        if (busy_o !== 1'b0 || resp_valid_o !== 1'b0) begin
            bad++;
            $display("FAIL to_flush got busy=%b pulse=%b, wanted 0 0", busy_o, resp_valid_o);
        end
        tick();
        tick();
    endtask

    task automatic test_async_reset();
        issue(2'd1, 32'hAAAA, 32'hBBBB, 4'd0, 1'b1);
        tick();
        cx_if.cx_req_ready_i = 1'b0;
        total++;
        if (busy_o !== 1'b1 || cx_if.cx_resp_ready_o !== 1'b1 || cx_if.cx_req_tag_o !== 3'd0) begin
            bad++;
            $display("FAIL ar_pre got busy=%b ready=%b tag=%0d, wanted 1 1 0",
                     busy_o, cx_if.cx_resp_ready_o, cx_if.cx_req_tag_o);
        end
        #1 rst = 1'b1;
        #1;
        total++;
        if (busy_o !== 1'b0 || cx_if.cx_resp_ready_o !== 1'b0 || cx_if.cx_req_op_a_o !== 32'd0 ||
            cx_if.cx_req_optype_o !== 2'd0 || resp_valid_o !== 1'b0 || result_o !== 32'd0) begin
            bad++;
            $display("FAIL ar_async got busy=%b ready=%b a=%h op=%0d pulse=%b result=%h, wanted all 0",
                     busy_o, cx_if.cx_resp_ready_o, cx_if.cx_req_op_a_o, cx_if.cx_req_optype_o,
                     resp_valid_o, result_o);
        end
        tick();
        rst = 1'b0;
        tick();
        issue(2'd2, 32'h5, 32'h6, 4'd0, 1'b1);
        total++;
        if (cx_if.cx_req_tag_o !== 3'd0 || cx_if.cx_req_op_a_o !== 32'h5) begin
            bad++;
            $display("FAIL ar_first_tag got tag=%0d a=%h, wanted 0 5", cx_if.cx_req_tag_o, cx_if.cx_req_op_a_o);
        end
        tick();
        cx_if.cx_req_ready_i  = 1'b0;
        cx_if.cx_resp_valid_i = 1'b1;
        cx_if.cx_resp_tag_i   = 3'd0;
        cx_if.cx_resp_data_i  = 32'h600D;
        expect_resp(32'h600D, 1'b0);
        tick();
        cx_if.cx_resp_valid_i = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_handshake();
        test_fixed();
        test_backpressure();
        test_flush_wait();
        test_timeout();
        test_async_reset();
        tick();
        total++;
        if (exp_q.size() != 0 || pulses != pushed) begin
            bad++;
            $display("FAIL pulse_count got pulses=%0d left=%0d, wanted %0d and 0", pulses, exp_q.size(), pushed);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
